mips_mc_ctrl: RTL

MIPS_MC_CTRL -- requirements
Module: mips_mc_ctrl

---
 rtl/mips_mc_ctrl_if.sv | 30 +++
 rtl/mips_mc_ctrl.sv | 98 +++++++++
 2 files changed

// File: rtl/mips_mc_ctrl_if.sv
// mips_mc_ctrl_if: instruction-side inputs and datapath-control outputs of the multicycle controller.
interface mips_mc_ctrl_if #(parameter int CNT_W = 16);
  logic             start;
  logic [31:0]      instr;
  logic             zero;
  logic [7:0]       pc;
  logic [31:0]      ir;
  logic             ir_write;
  logic             reg_write;
  logic             mem_read;
  logic             mem_write;
  logic             alu_src_b;
  logic             reg_dst;
  logic             mem_to_reg;
  logic [2:0]       alu_op;
  logic [2:0]       state;
  logic             done;
  logic             err;
  logic [CNT_W-1:0] instr_count;
  modport master (
    output start, instr, zero,
    input  pc, ir, ir_write, reg_write, mem_read, mem_write, alu_src_b,
           reg_dst, mem_to_reg, alu_op, state, done, err, instr_count
  );
  modport slave (
    input  start, instr, zero,
    output pc, ir, ir_write, reg_write, mem_read, mem_write, alu_src_b,
           reg_dst, mem_to_reg, alu_op, state, done, err, instr_count
  );
endinterface

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multicycle MIPS-subset controller (add/sub/and/or/slt, lw, sw, beq) with halt and error detection.
module mips_mc_ctrl #(parameter int CNT_W = 16) (
  input  logic          clk,
  input  logic          rst_n,
  mips_mc_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_BAD
  } state_e;
  state_e           state_q, state_d;
  logic [7:0]       pc_q, pc_d;
  logic [31:0]      ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d, err_q, err_d;
  logic [5:0]       op, funct;
  logic             is_r, is_lw, is_sw, is_beq, retire;
  logic [2:0]       alu_r;
  assign op     = ir_q[31:26];
  assign funct  = ir_q[5:0];
  assign is_lw  = op == 6'h23;
  assign is_sw  = op == 6'h2b;
  assign is_beq = op == 6'h04;
  always_comb begin
    alu_r = funct == 6'h20 ? 3'b000 :
            funct == 6'h22 ? 3'b001 :
            funct == 6'h24 ? 3'b010 :
            funct == 6'h25 ? 3'b011 :
            funct == 6'h2a ? 3'b100 : 3'b111;
    is_r  = op == 6'h00 && alu_r != 3'b111;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    done_d  = done_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE:   state_d = bus.start ? S_FETCH : S_IDLE;
      S_FETCH: begin
        ir_d    = bus.instr;
        pc_d    = pc_q + 8'd1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        state_d = (is_r || is_lw || is_sw || is_beq) && ir_q != '0 ? S_EXEC : S_HALT;
        done_d  = ir_q == '0;
        err_d   = ir_q != '0 && !(is_r || is_lw || is_sw || is_beq);
      end
      S_EXEC: begin
        state_d = is_r ? S_WB : (is_lw || is_sw) ? S_MEM : S_FETCH;
        pc_d    = is_beq && bus.zero ? pc_q + ir_q[7:0] : pc_q;
      end
      S_MEM:    state_d = is_lw ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default: begin
        state_d = S_HALT;
        err_d   = 1'b1;
      end
    endcase
    retire = state_d == S_FETCH && (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB);
    cnt_d  = retire && !(&cnt_q) ? cnt_q + 1'b1 : cnt_q;
  end
  // Strobes are pure decodes of the current state and latched instruction.
  always_comb begin
    bus.ir_write   = state_q == S_FETCH;
    bus.mem_read   = state_q == S_MEM && is_lw;
    bus.mem_write  = state_q == S_MEM && is_sw;
    bus.reg_write  = state_q == S_WB;
    bus.reg_dst    = state_q == S_WB && is_r;
    bus.mem_to_reg = state_q == S_WB && is_lw;
    bus.alu_src_b  = state_q == S_EXEC && (is_lw || is_sw);
    bus.alu_op     = state_q != S_EXEC ? 3'b000 : is_r ? alu_r : is_beq ? 3'b001 : 3'b000;
  end
  assign bus.pc          = pc_q;
  assign bus.ir          = ir_q;
  assign bus.state       = state_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;
  assign bus.instr_count = cnt_q;
endmodule
